// File: rtl/vdp_port.sv
// ---------------------------------------------------------------------------
// vdp_port : CPU-side TMS9918-style port front end for the MSX VDP.
//
// Decodes Z80 accesses to the data port (cpu_port=0, I/O 0x98) and the
// control/status port (cpu_port=1, I/O 0x99). Owns the VRAM address pointer,
// the one-byte read-ahead buffer, the write-only registers R0..R7, the status
// register and the frame interrupt.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cpu_port/din/wr/rd         CPU access (port select, data, strobes)
//   cpu_dout, cpu_wait         read data (held until next read), busy flag
//   vga_addr/din/wr/rd/dout    VRAM access port (read data 1 cycle late)
//   frame_pulse, sprite_*      status sources from the video generator
//   mode, *_addr, colours,
//   sprite/video flags         register-derived configuration
//   n_int                      active-low frame interrupt
//
// Optional feature: define VDP_TABLE_MASK_EN to apply Graphics II (mode 2)
// masking of the colour and pattern table bases.
// ---------------------------------------------------------------------------
module vdp_port #(
  parameter int ADDR_W = 14,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_port,
  input  logic [7:0]        cpu_din,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  output logic [7:0]        cpu_dout,
  output logic              cpu_wait,
  output logic [ADDR_W-1:0] vga_addr,
  output logic [7:0]        vga_din,
  output logic              vga_wr,
  output logic              vga_rd,
  input  logic [7:0]        vga_dout,
  input  logic              frame_pulse,
  input  logic              sprite_collision,
  input  logic              too_many_sprites,
  input  logic [4:0]        sprite5,
  output logic [1:0]        mode,
  output logic [13:0]       name_table_addr,
  output logic [13:0]       color_table_addr,
  output logic [13:0]       font_addr,
  output logic [13:0]       sprite_attr_addr,
  output logic [13:0]       sprite_pattern_table_addr,
  output logic              video_on,
  output logic              sprite_large,
  output logic              sprite_enlarged,
  output logic              vert_retrace_int,
  output logic [3:0]        text_color,
  output logic [3:0]        back_color,
  output logic              n_int
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t            state_r, state_nx;
  logic [7:0]        regs_r [NREGS];
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        latch_r;
  logic              flag_r;       // second-byte flag of the control port
  logic [7:0]        rbuf_r;       // read-ahead buffer
  logic [7:0]        dout_r;
  logic              f_r, s5_r, c_r;
  logic [4:0]        spr5_r;

  logic busy_s, data_wr_s, ctl_wr_s, data_rd_s, stat_rd_s, launch_s;

  // Strobe qualification: everything is ignored while busy, write beats read.
  always_comb begin
    busy_s    = (state_r != ST_IDLE);
    data_wr_s = cpu_wr & ~busy_s & ~cpu_port;
    ctl_wr_s  = cpu_wr & ~busy_s &  cpu_port;
    data_rd_s = cpu_rd & ~cpu_wr & ~busy_s & ~cpu_port;
    stat_rd_s = cpu_rd & ~cpu_wr & ~busy_s &  cpu_port;
    launch_s  = data_rd_s | (ctl_wr_s & flag_r & (cpu_din[7:6] == 2'b00));
  end

  // Prefetch FSM next-state logic.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE: begin
        if (launch_s) begin
          state_nx = ST_FETCH;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_FETCH:   state_nx = ST_CAPTURE;
      ST_CAPTURE: state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // Prefetch FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // CPU-side datapath: register file, address pointer, buffers, read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= 8'h00;
      end
      addr_r  <= '0;
      latch_r <= 8'h00;
      flag_r  <= 1'b0;
      rbuf_r  <= 8'h00;
      dout_r  <= 8'h00;
    end else begin
      if (ctl_wr_s) begin
        if (!flag_r) begin
          latch_r <= cpu_din;
          flag_r  <= 1'b1;
        end else begin
          flag_r <= 1'b0;
          if (cpu_din[7]) begin
            for (int i = 0; i < NREGS; i++) begin
              if (cpu_din[2:0] == 3'(i)) begin
                regs_r[i] <= latch_r;
              end
            end
          end else begin
            addr_r <= ADDR_W'({cpu_din[5:0], latch_r});
          end
        end
      end else if (data_wr_s) begin
        rbuf_r <= cpu_din;
        addr_r <= addr_r + ADDR_W'(1);
        flag_r <= 1'b0;
      end else if (data_rd_s) begin
        dout_r <= rbuf_r;
        flag_r <= 1'b0;
      end else if (stat_rd_s) begin
        dout_r <= {f_r, s5_r, c_r, spr5_r};
        flag_r <= 1'b0;
      end else if (state_r == ST_CAPTURE) begin
        // vga_dout now holds the byte requested during FETCH.
        rbuf_r <= vga_dout;
        addr_r <= addr_r + ADDR_W'(1);
      end
    end
  end

  // Status flags: a same-cycle set outranks the clear from a status read.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_r    <= 1'b0;
      s5_r   <= 1'b0;
      c_r    <= 1'b0;
      spr5_r <= 5'd0;
    end else begin
      f_r  <= frame_pulse      | (f_r  & ~stat_rd_s);
      c_r  <= sprite_collision | (c_r  & ~stat_rd_s);
      s5_r <= too_many_sprites | (s5_r & ~stat_rd_s);
      // Keep the first offending sprite number until 5S is cleared.
      if (too_many_sprites && !s5_r) begin
        spr5_r <= sprite5;
      end
    end
  end

  // VRAM port and CPU-visible status; reset drops strobes immediately.
  always_comb begin
    cpu_wait = busy_s & ~reset;
    cpu_dout = dout_r;
    vga_addr = addr_r;
    vga_din  = cpu_din;
    vga_wr   = data_wr_s & ~reset;
    vga_rd   = (state_r == ST_FETCH) & ~reset;
    n_int    = ~(f_r & regs_r[1][5]);
  end

  // Register-derived configuration for the video generator.
  always_comb begin
    if (regs_r[1][4]) begin
      mode = 2'd0;
    end else if (regs_r[1][3]) begin
      mode = 2'd3;
    end else if (regs_r[0][1]) begin
      mode = 2'd2;
    end else begin
      mode = 2'd1;
    end
    name_table_addr           = {regs_r[2][3:0], 10'd0};
    sprite_attr_addr          = {regs_r[5][6:0], 7'd0};
    sprite_pattern_table_addr = {regs_r[6][2:0], 11'd0};
`ifdef VDP_TABLE_MASK_EN
    if (mode == 2'd2) begin
      color_table_addr = {regs_r[3][7], 13'd0};
      font_addr        = {regs_r[4][2], 13'd0};
    end else begin
      color_table_addr = {regs_r[3], 6'd0};
      font_addr        = {regs_r[4][2:0], 11'd0};
    end
`else
    color_table_addr = {regs_r[3], 6'd0};
    font_addr        = {regs_r[4][2:0], 11'd0};
`endif
    video_on         = regs_r[1][6];
    vert_retrace_int = regs_r[1][5];
    sprite_large     = regs_r[1][1];
    sprite_enlarged  = regs_r[1][0];
    text_color       = regs_r[7][7:4];
    back_color       = regs_r[7][3:0];
  end

  // Register bits with no function in this front end.
  logic unused_reg_bits;
  assign unused_reg_bits = &{1'b0, regs_r[0][7:2], regs_r[0][0], regs_r[1][7],
                             regs_r[1][2], regs_r[2][7:4], regs_r[4][7:3],
                             regs_r[5][7], regs_r[6][7:3]};

endmodule

// File: tb/tb_vdp_port.sv
module tb_vdp_port;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_port = 1'b0;
  logic [7:0]  cpu_din = 8'h00;
  logic        cpu_wr = 1'b0;
  logic        cpu_rd = 1'b0;
  logic [7:0]  cpu_dout;
  logic        cpu_wait;
  logic [13:0] vga_addr;
  logic [7:0]  vga_din;
  logic        vga_wr;
  logic        vga_rd;
  logic [7:0]  vga_dout = 8'h00;
  logic        frame_pulse = 1'b0;
  logic        sprite_collision = 1'b0;
  logic        too_many_sprites = 1'b0;
  logic [4:0]  sprite5 = 5'd0;
  logic [1:0]  mode;
  logic [13:0] name_table_addr, color_table_addr, font_addr;
  logic [13:0] sprite_attr_addr, sprite_pattern_table_addr;
  logic        video_on, sprite_large, sprite_enlarged, vert_retrace_int;
  logic [3:0]  text_color, back_color;
  logic        n_int;

  int total = 0;
  int bad = 0;

  logic [21:0] wr_q[$];   // expected VRAM writes {addr, data}
  logic [13:0] rd_q[$];   // expected VRAM prefetch addresses
  logic [7:0]  dout_q[$]; // expected CPU read data

  vdp_port dut (
    .clk(clk), .reset(reset), .cpu_port(cpu_port), .cpu_din(cpu_din),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_dout(cpu_dout), .cpu_wait(cpu_wait),
    .vga_addr(vga_addr), .vga_din(vga_din), .vga_wr(vga_wr), .vga_rd(vga_rd),
    .vga_dout(vga_dout), .frame_pulse(frame_pulse),
    .sprite_collision(sprite_collision), .too_many_sprites(too_many_sprites),
    .sprite5(sprite5), .mode(mode), .name_table_addr(name_table_addr),
    .color_table_addr(color_table_addr), .font_addr(font_addr),
    .sprite_attr_addr(sprite_attr_addr),
    .sprite_pattern_table_addr(sprite_pattern_table_addr),
    .video_on(video_on), .sprite_large(sprite_large),
    .sprite_enlarged(sprite_enlarged), .vert_retrace_int(vert_retrace_int),
    .text_color(text_color), .back_color(back_color), .n_int(n_int)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] vram_val(input logic [13:0] a);
    if (a == 14'h1000) return 8'h5A;
    else if (a == 14'h1001) return 8'hC3;
    else return a[7:0] ^ 8'h96;
  endfunction

  // VRAM read model with one cycle of latency
  always @(posedge clk) begin
    if (vga_rd) vga_dout <= vram_val(vga_addr);
  end

  // Scoreboard monitor for VRAM-side strobes
  always @(negedge clk) begin : mon
    logic [21:0] e;
    if (vga_wr === 1'b1) begin
      if (wr_q.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
      else begin
        e = wr_q.pop_front();
        chk("wr_addr", {18'd0, vga_addr}, {18'd0, e[21:8]});
        chk("wr_data", {24'd0, vga_din}, {24'd0, e[7:0]});
      end
    end
    if (vga_rd === 1'b1) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
      else chk("rd_addr", {18'd0, vga_addr}, {18'd0, rd_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl_wr(input logic [7:0] d);
    cpu_port = 1'b1; cpu_din = d; cpu_wr = 1'b1;
    tick();
    cpu_wr = 1'b0;
  endtask

  task automatic reg_wr(input logic [7:0] val, input logic [2:0] r);
    ctl_wr(val);
    ctl_wr({5'b10000, r});
  endtask

  task automatic data_wr(input logic [7:0] d, input logic [13:0] a);
    wr_q.push_back({a, d});
    cpu_port = 1'b0; cpu_din = d; cpu_wr = 1'b1;
    tick();
    cpu_wr = 1'b0;
  endtask

  task automatic do_rd(input string tag, input logic port, input logic [7:0] exp);
    dout_q.push_back(exp);
    cpu_port = port; cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
    chk(tag, {24'd0, cpu_dout}, {24'd0, dout_q.pop_front()});
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cpu_wait === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("wait_bound", {31'd0, cpu_wait}, 32'd0);
  endtask

  initial begin
    int n;
    tick(); tick();
    reset = 1'b0;
    // reset state
    chk("rst_mode", {30'd0, mode}, 32'd1);
    chk("rst_video_on", {31'd0, video_on}, 32'd0);
    chk("rst_n_int", {31'd0, n_int}, 32'd1);
    chk("rst_wait", {31'd0, cpu_wait}, 32'd0);
    chk("rst_dout", {24'd0, cpu_dout}, 32'd0);
    chk("rst_addr", {18'd0, vga_addr}, 32'd0);
    chk("rst_name", {18'd0, name_table_addr}, 32'd0);

    // register writes and mode decode
    reg_wr(8'h00, 3'd1);
    chk("r1_00_mode", {30'd0, mode}, 32'd1);
    reg_wr(8'h50, 3'd1);
    chk("r1_50_video_on", {31'd0, video_on}, 32'd1);
    chk("r1_50_mode", {30'd0, mode}, 32'd0);
    reg_wr(8'h0F, 3'd2);
    reg_wr(8'hFF, 3'd3);
    reg_wr(8'h07, 3'd4);
    reg_wr(8'h7F, 3'd5);
    reg_wr(8'h07, 3'd6);
    reg_wr(8'hF4, 3'd7);
    chk("name_base", {18'd0, name_table_addr}, 32'h3C00);
    chk("color_base", {18'd0, color_table_addr}, 32'h3FC0);
    chk("font_base", {18'd0, font_addr}, 32'h3800);
    chk("sattr_base", {18'd0, sprite_attr_addr}, 32'h3F80);
    chk("spat_base", {18'd0, sprite_pattern_table_addr}, 32'h3800);
    chk("colours", {24'd0, text_color, back_color}, 32'hF4);
    reg_wr(8'h02, 3'd0);
    reg_wr(8'h00, 3'd1);
    chk("mode2", {30'd0, mode}, 32'd2);
`ifdef VDP_TABLE_MASK_EN
    chk("mode2_color", {18'd0, color_table_addr}, 32'h2000);
    chk("mode2_font", {18'd0, font_addr}, 32'h2000);
`else
    chk("mode2_color", {18'd0, color_table_addr}, 32'h3FC0);
    chk("mode2_font", {18'd0, font_addr}, 32'h3800);
`endif
    reg_wr(8'h0B, 3'd1);
    chk("mode3", {30'd0, mode}, 32'd3);
    chk("r1_bits", {28'd0, video_on, vert_retrace_int, sprite_large, sprite_enlarged}, 32'h3);

    // write setup and consecutive data writes
    ctl_wr(8'h34); ctl_wr(8'h52);
    data_wr(8'hAA, 14'h1234);
    data_wr(8'hBB, 14'h1235);
    chk("addr_after_wr", {18'd0, vga_addr}, 32'h1236);

    // address wrap at the top of VRAM
    ctl_wr(8'hFF); ctl_wr(8'h7F);
    data_wr(8'h11, 14'h3FFF);
    chk("addr_wrap", {18'd0, vga_addr}, 32'h0000);

    // read setup with prefetch
    rd_q.push_back(14'h1000);
    ctl_wr(8'h00); ctl_wr(8'h10);
    n = 0;
    while (cpu_wait === 1'b1 && n < 10) begin
      n++;
      tick();
    end
    chk("wait_cycles", n, 32'd2);
    rd_q.push_back(14'h1001);
    do_rd("rd_first", 1'b0, 8'h5A);
    // a write while busy must be dropped (no vga_wr, no address step)
    cpu_port = 1'b0; cpu_din = 8'h77; cpu_wr = 1'b1;
    tick();
    cpu_wr = 1'b0;
    wait_idle();
    rd_q.push_back(14'h1002);
    do_rd("rd_second", 1'b0, 8'hC3);
    wait_idle();
    chk("addr_after_rd", {18'd0, vga_addr}, 32'h1003);

    // frame interrupt and status reads
    reg_wr(8'h20, 3'd1);
    chk("n_int_idle", {31'd0, n_int}, 32'd1);
    frame_pulse = 1'b1; tick(); frame_pulse = 1'b0;
    chk("n_int_frame", {31'd0, n_int}, 32'd0);
    do_rd("stat_f", 1'b1, 8'h80);
    chk("n_int_cleared", {31'd0, n_int}, 32'd1);
    frame_pulse = 1'b1;
    do_rd("stat_f_race", 1'b1, 8'h00);
    frame_pulse = 1'b0;
    chk("n_int_race", {31'd0, n_int}, 32'd0);
    reg_wr(8'h00, 3'd1);
    chk("n_int_masked", {31'd0, n_int}, 32'd1);
    reg_wr(8'h20, 3'd1);
    chk("n_int_retained", {31'd0, n_int}, 32'd0);
    do_rd("stat_f_again", 1'b1, 8'h80);

    // sprite status: collision, fifth sprite latched only once
    sprite_collision = 1'b1; too_many_sprites = 1'b1; sprite5 = 5'h0A;
    tick();
    sprite5 = 5'h03;
    tick();
    sprite_collision = 1'b0; too_many_sprites = 1'b0;
    do_rd("stat_sprite", 1'b1, 8'h6A);
    do_rd("stat_cleared", 1'b1, 8'h0A);

    // status read resets the second-byte flag
    ctl_wr(8'h12);
    do_rd("stat_flag", 1'b1, 8'h0A);
    ctl_wr(8'h87);
    chk("r7_kept", {24'd0, text_color, back_color}, 32'hF4);
    ctl_wr(8'h81);
    chk("r1_from_87", {28'd0, video_on, vert_retrace_int, sprite_large, sprite_enlarged}, 32'h3);

    // simultaneous write and read: only the write happens
    ctl_wr(8'h00); ctl_wr(8'h45);
    wr_q.push_back({14'h0500, 8'h3C});
    cpu_port = 1'b0; cpu_din = 8'h3C; cpu_wr = 1'b1; cpu_rd = 1'b1;
    tick();
    cpu_wr = 1'b0; cpu_rd = 1'b0;
    chk("wr_rd_dout", {24'd0, cpu_dout}, 32'h0A);
    chk("wr_rd_wait", {31'd0, cpu_wait}, 32'd0);
    chk("wr_rd_addr", {18'd0, vga_addr}, 32'h0501);

    // reset during a prefetch
    ctl_wr(8'h00);
    cpu_port = 1'b1; cpu_din = 8'h20; cpu_wr = 1'b1;
    tick();
    cpu_wr = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_wait", {31'd0, cpu_wait}, 32'd0);
    chk("abort_addr", {18'd0, vga_addr}, 32'd0);
    chk("abort_mode", {30'd0, mode}, 32'd1);
    rd_q.push_back(14'h0000);
    do_rd("abort_buf", 1'b0, 8'h00);
    wait_idle();
    chk("abort_addr_next", {18'd0, vga_addr}, 32'd1);

    tick();
    chk("wr_q_empty", wr_q.size(), 32'd0);
    chk("rd_q_empty", rd_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
